// File: rtl/collision_map_pkg.sv
// Shared geometry, direction bit offsets and FSM encoding for the collision map writer and reader.
package collision_map_pkg;

    localparam int unsigned COLS   = 19;
    localparam int unsigned ROWS   = 32;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned MAP_W  = 2;
    localparam int unsigned ADDR_W = MAP_W + ROW_W;

    // Bit offsets of each move inside a tile's 4-bit nibble.
    localparam int unsigned DIR_W     = 4;
    localparam int unsigned DIR_LEFT  = 0;
    localparam int unsigned DIR_RIGHT = 1;
    localparam int unsigned DIR_UP    = 2;
    localparam int unsigned DIR_DOWN  = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/collision_row_calc.sv
// Combinational valid-move calculation for one map row from its wall row and vertical neighbours.
// With COLLISION_TUNNEL_EN defined the left/right edges wrap horizontally; otherwise they are walls.
module collision_row_calc #(
    parameter int unsigned COLS = collision_map_pkg::COLS
) (
    input  logic [COLS-1:0]       prev_row_i,
    input  logic [COLS-1:0]       cur_row_i,
    input  logic [COLS-1:0]       next_row_i,
    output logic [4*COLS-1:0]     moves_o
);
    import collision_map_pkg::*;

    for (genvar x = 0; x < COLS; x++) begin : g_tile
        logic left_wall;
        logic right_wall;

        if (x == 0) begin : g_left
`ifdef COLLISION_TUNNEL_EN
            assign left_wall = cur_row_i[COLS-1];
`else
            assign left_wall = 1'b1;
`endif
        end else begin : g_left
            assign left_wall = cur_row_i[x-1];
        end

        if (x == COLS-1) begin : g_right
`ifdef COLLISION_TUNNEL_EN
            assign right_wall = cur_row_i[0];
`else
            assign right_wall = 1'b1;
`endif
        end else begin : g_right
            assign right_wall = cur_row_i[x+1];
        end

        // A wall tile allows no moves; otherwise a move is open when the neighbour is not a wall.
        assign moves_o[DIR_W*x + DIR_LEFT]  = ~cur_row_i[x] & ~left_wall;
        assign moves_o[DIR_W*x + DIR_RIGHT] = ~cur_row_i[x] & ~right_wall;
        assign moves_o[DIR_W*x + DIR_UP]    = ~cur_row_i[x] & ~prev_row_i[x];
        assign moves_o[DIR_W*x + DIR_DOWN]  = ~cur_row_i[x] & ~next_row_i[x];
    end

endmodule

// File: rtl/collision_map_writer.sv
// Rebuilds one collision map: streams wall rows from ROM, writes packed valid-move rows to RAM.
// Optional horizontal wrap (tunnel) enabled by defining COLLISION_TUNNEL_EN.
module collision_map_writer #(
    parameter int unsigned COLS   = collision_map_pkg::COLS,
    parameter int unsigned ROWS   = collision_map_pkg::ROWS,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                                clk_100mhz,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [collision_map_pkg::MAP_W-1:0] map_num,
    output logic [collision_map_pkg::ADDR_W-1:0] wall_addr,
    input  logic [COLS-1:0]                     wall_row,
    output logic                                wr_en,
    output logic [collision_map_pkg::ADDR_W-1:0] wr_addr,
    output logic [4*COLS-1:0]                   wr_data,
    output logic                                busy,
    output logic                                done
);
    import collision_map_pkg::*;

    // Only a one-cycle ROM is supported; any other latency keeps the block idle.
    localparam bit LAT_OK = (RD_LAT == 1);

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [MAP_W-1:0]       map_q, map_d;
    logic [COLS-1:0]        prev_q, prev_d;
    logic [COLS-1:0]        cur_q, cur_d;
    logic [ADDR_W-1:0]      wall_addr_q, wall_addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [4*COLS-1:0]      wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [COLS-1:0]        calc_next;
    logic [4*COLS-1:0]      calc_moves;

    // Window is {prev_q, cur_q, incoming row}; FLUSH supplies the all-wall row below the map.
    assign calc_next = (state_q == FLUSH) ? '1 : wall_row;

    collision_row_calc #(.COLS(COLS)) u_row_calc (
        .prev_row_i (prev_q),
        .cur_row_i  (cur_q),
        .next_row_i (calc_next),
        .moves_o    (calc_moves)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        map_d       = map_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        wall_addr_d = wall_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_q && LAT_OK) begin
                    state_d     = ISSUE;
                    map_d       = map_num;
                    row_d       = '0;
                    prev_d      = '1;
                    cur_d       = '1;
                    busy_d      = 1'b1;
                    wall_addr_d = {map_num, ROW_W'(0)};
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                prev_d = cur_q;
                cur_d  = wall_row;
                if (row_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {map_q, row_q - ROW_W'(1)};
                    wr_data_d = calc_moves;
                end
                if (row_q == ROW_W'(ROWS-1)) begin
                    state_d = FLUSH;
                end else begin
                    row_d       = row_q + ROW_W'(1);
                    wall_addr_d = {map_q, row_q + ROW_W'(1)};
                    state_d     = ISSUE;
                end
            end
            FLUSH: begin
                prev_d    = cur_q;
                cur_d     = '1;
                wr_en_d   = 1'b1;
                wr_addr_d = {map_q, ROW_W'(ROWS-1)};
                wr_data_d = calc_moves;
                state_d   = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            map_q       <= '0;
            prev_q      <= '1;
            cur_q       <= '1;
            wall_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            map_q       <= map_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            wall_addr_q <= wall_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign wall_addr = wall_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_collision_map_writer.sv
// Directed bench for collision_map_writer: wall-ROM model, write capture, tile vector table.
module tb_collision_map_writer;

    localparam int unsigned COLS = 19;
`ifdef COLLISION_TUNNEL_EN
    localparam bit TUN = 1'b1;
`else
    localparam bit TUN = 1'b0;
`endif

    logic                 clk_100mhz = 1'b0;
    logic                 rst_n      = 1'b0;
    logic                 start      = 1'b0;
    logic [1:0]           map_num    = 2'd0;
    logic [6:0]           wall_addr;
    logic [COLS-1:0]      wall_row;
    logic                 wr_en;
    logic [6:0]           wr_addr;
    logic [4*COLS-1:0]    wr_data;
    logic                 busy;
    logic                 done;

    collision_map_writer dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .start      (start),
        .map_num    (map_num),
        .wall_addr  (wall_addr),
        .wall_row   (wall_row),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // One-cycle-latency wall ROM.
    logic [COLS-1:0] rom [128];
    always @(posedge clk_100mhz) wall_row <= rom[wall_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write capture and timing monitor; cycle 0 is the cycle after the edge that samples start.
    logic [4*COLS-1:0] captured [128];
    int gcyc = 0, base = 0;
    int wr_cnt, nz_cnt, done_cnt, order_err, first_wr, last_wr, done_cyc, exp_addr;
    logic [6:0] wa0, wa40;
    logic       busy30;

    always @(posedge clk_100mhz) gcyc <= gcyc + 1;

    always @(negedge clk_100mhz) begin
        if (wr_en) begin
            captured[wr_addr] = wr_data;
            if (wr_cnt == 0) first_wr = gcyc - base;
            last_wr = gcyc - base;
            if (int'(wr_addr) != exp_addr) order_err++;
            exp_addr++;
            if (wr_data != '0) nz_cnt++;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = gcyc - base;
        end
    end

    task automatic build(input logic [1:0] m, input int pulse_a, input int chg_cyc, input int rst_cyc);
        @(negedge clk_100mhz);
        wr_cnt = 0; nz_cnt = 0; done_cnt = 0; order_err = 0;
        first_wr = -1; last_wr = -1; done_cyc = -1;
        exp_addr = int'(m) * 32;
        base = gcyc + 1;
        start = 1'b1;
        map_num = m;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk_100mhz);
            start = (k == pulse_a) || (rst_cyc < 0 && k == 66);
            if (k == chg_cyc) map_num = m + 2'd1;
            if (k == 0)  wa0 = wall_addr;
            if (k == 30) busy30 = busy;
            if (k == 40) wa40 = wall_addr;
            if (k == rst_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_wr_en", wr_en, 0);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_done", done, 0);
                check("mid_rst_wall_addr", wall_addr, 0);
            end
            if (k == rst_cyc + 3) rst_n = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic check_build(input int m, input string tag);
        check({tag, "_wr_count"}, wr_cnt, 32);
        check({tag, "_first_wr"}, first_wr, 4);
        check({tag, "_last_wr"}, last_wr, 65);
        check({tag, "_done_cyc"}, done_cyc, 66);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_order_err"}, order_err, 0);
        check({tag, "_wall_addr_c0"}, wa0, m * 32);
        check({tag, "_wall_addr_c40"}, wa40, m * 32 + 20);
        check({tag, "_busy_c30"}, busy30, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    typedef struct {
        string      name;
        int         addr;
        int         tile;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [3:0] nib;

        vecs[0]  = '{"m0_r0_t5",    0, 5,  4'b1011};
        vecs[1]  = '{"m0_r31_t0",   31, 0, TUN ? 4'b0111 : 4'b0110};
        vecs[2]  = '{"m0_r15_t9",   15, 9, 4'b1111};
        vecs[3]  = '{"m0_r0_t18",   0, 18, TUN ? 4'b1011 : 4'b1001};
        vecs[4]  = '{"m0_r31_t18",  31, 18, TUN ? 4'b0111 : 4'b0101};
        vecs[5]  = '{"m3_r10_t3",   96+10, 3, 4'b0000};
        vecs[6]  = '{"m1_r10_t7",   32+10, 7, 4'b0000};
        vecs[7]  = '{"m1_r10_t6",   32+10, 6, 4'b0000};
        vecs[8]  = '{"m1_r9_t7",    32+9, 7, 4'b0000};
        vecs[9]  = '{"m2_r10_t0",   64+10, 0, TUN ? 4'b1111 : 4'b1110};
        vecs[10] = '{"m2_r9_t5",    64+9, 5, 4'b1011};
        vecs[11] = '{"m2_r11_t18",  64+11, 18, TUN ? 4'b0111 : 4'b0101};
        vecs[12] = '{"m2_r8_t0",    64+8, 0, 4'b0000};
        vecs[13] = '{"m2_r20_t4",   64+20, 4, 4'b0010};
        vecs[14] = '{"m2_r20_t5",   64+20, 5, 4'b0001};
        vecs[15] = '{"m2_r10_t18",  64+10, 18, TUN ? 4'b1111 : 4'b1101};

        // Map 0 all open, map 1 one open tile, map 2 open band plus a gap row, map 3 all wall.
        for (int r = 0; r < 32; r++) begin
            rom[r]      = '0;
            rom[32 + r] = '1;
            rom[64 + r] = (r >= 9 && r <= 11) ? '0 : '1;
            rom[96 + r] = '1;
        end
        rom[32 + 10][7] = 1'b0;
        rom[64 + 20]    = 19'h7FFCF;
        for (int a = 0; a < 128; a++) captured[a] = '0;

        #3;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wall_addr", wall_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk_100mhz);
        rst_n = 1'b1;

        build(2'd0, -1, -1, -1);
        check_build(0, "open");
        build(2'd3, -1, -1, -1);
        check_build(3, "wall");
        check("wall_nonzero_rows", nz_cnt, 0);
        build(2'd1, -1, -1, -1);
        check_build(1, "single");
        check("single_nonzero_rows", nz_cnt, 0);
        build(2'd2, -1, -1, -1);
        check_build(2, "band");

        for (int i = 0; i < 16; i++) begin
            nib = captured[vecs[i].addr][4*vecs[i].tile +: 4];
            check(vecs[i].name, nib, vecs[i].exp);
        end

        // Restart pulse mid-build and map_num changing 1->2 must not disturb the build.
        for (int a = 32; a < 64; a++) captured[a] = '1;
        build(2'd1, 30, 10, -1);
        check_build(1, "restart");
        nib = captured[32 + 10][4*7 +: 4];
        check("restart_m1_r10_t7", nib, 4'b0000);

        // Reset in cycle 20 abandons the build; rows 0..8 were written before it.
        build(2'd0, -1, -1, 20);
        check("rst_build_wr_count", wr_cnt, 9);
        check("rst_build_done_count", done_cnt, 0);
        check("rst_build_busy_end", busy, 0);
        for (int a = 0; a < 32; a++) captured[a] = '1;
        build(2'd0, -1, -1, -1);
        check_build(0, "after_rst");
        nib = captured[0][4*5 +: 4];
        check("after_rst_m0_r0_t5", nib, 4'b1011);
        nib = captured[15][4*9 +: 4];
        check("after_rst_m0_r15_t9", nib, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
